// File: rtl/phase_detector_lock_if.sv
// Measurement-side signals of the ADPLL phase detector: async clock inputs,
// enable, and the error/slip/lock results for the loop controller.
interface phase_detector_lock_if #(
  parameter int ERR_W = 8
);
  logic                    enable_i;
  logic                    ref_clk_i;
  logic                    gen_clk_i;
  logic signed [ERR_W-1:0] error_o;
  logic                    error_valid_o;
  logic                    slip_o;
  logic                    locked_o;

  modport master (
    output enable_i, ref_clk_i, gen_clk_i,
    input  error_o, error_valid_o, slip_o, locked_o
  );

  modport slave (
    input  enable_i, ref_clk_i, gen_clk_i,
    output error_o, error_valid_o, slip_o, locked_o
  );
endinterface

// File: rtl/phase_detector_lock.sv
// Time-interval phase detector: times ref/gen rising-edge gaps in fpga_clk_i
// cycles, emits a saturated signed error, and tracks lock with hysteresis.
module phase_detector_lock #(
  parameter int ERR_W       = 8,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_CNT  = 4
) (
  input logic                  fpga_clk_i,
  input logic                  reset_ni,
  phase_detector_lock_if.slave bus_if
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IN_W  = $clog2(LOCK_CNT + 1);
  localparam int OUT_W = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned ERR_MAX = (32'd1 << (ERR_W - 1)) - 32'd1;
  localparam int unsigned TOL = LOCK_TOL;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IN_W-1:0]  IN_FULL  = IN_W'(LOCK_CNT);
  localparam logic [OUT_W-1:0] OUT_FULL = OUT_W'(UNLOCK_CNT);

  typedef enum logic [1:0] {IDLE, WAIT_GEN, WAIT_REF} state_e;

  logic [SYNC_STAGES-1:0] ref_sync_q, gen_sync_q;
  logic                   ref_prev_q, gen_prev_q;
  logic                   ref_e_q, gen_e_q;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IN_W-1:0]  in_cnt_q;
  logic [OUT_W-1:0] out_cnt_q;
  logic [ERR_W-1:0] error_q;
  logic             valid_q, slip_q, locked_q;

  logic             waiting, lead_neg, partner_e, same_e, expired;
  logic             result, slip_hit, in_window;
  logic [ERR_W-1:0] err_mag, err_d;

  // Measured interval is cnt+1; clamp keeps the range symmetric about zero.
  function automatic logic [ERR_W-1:0] clamp_mag(input logic [CNT_W-1:0] c);
    if (32'(c) >= ERR_MAX) return ERR_W'(ERR_MAX);
    return ERR_W'(c) + ERR_W'(1);
  endfunction

  // NOTE: all state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ref_sync_q <= '0;
      gen_sync_q <= '0;
      ref_prev_q <= 1'b0;
      gen_prev_q <= 1'b0;
      ref_e_q    <= 1'b0;
      gen_e_q    <= 1'b0;
    end else begin
      ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], bus_if.ref_clk_i};
      gen_sync_q <= {gen_sync_q[SYNC_STAGES-2:0], bus_if.gen_clk_i};
      ref_prev_q <= ref_sync_q[SYNC_STAGES-1];
      gen_prev_q <= gen_sync_q[SYNC_STAGES-1];
      ref_e_q    <= ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
      gen_e_q    <= gen_sync_q[SYNC_STAGES-1] & ~gen_prev_q;
    end
  end

  // NOTE: every output of this block gets a value on every path, so no
  // latches are inferred.
  always_comb begin
    waiting   = (state_q == WAIT_GEN) || (state_q == WAIT_REF);
    lead_neg  = (state_q == WAIT_REF);
    partner_e = lead_neg ? ref_e_q : gen_e_q;
    same_e    = lead_neg ? gen_e_q : ref_e_q;
    expired   = waiting && (cnt_q == CNT_LAST);
    if (waiting) begin
      result   = partner_e || same_e || expired;
      slip_hit = !partner_e && (same_e || expired);
    end else begin
      result   = (state_q == IDLE) && ref_e_q && gen_e_q;
      slip_hit = 1'b0;
    end
    err_mag = '0;
    if (waiting) err_mag = slip_hit ? ERR_W'(ERR_MAX) : clamp_mag(cnt_q);
    err_d     = lead_neg ? ('0 - err_mag) : err_mag;
    in_window = !slip_hit && (32'(err_mag) <= TOL);
  end

  always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      error_q   <= '0;
      valid_q   <= 1'b0;
      slip_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else if (!bus_if.enable_i) begin
      // error_q deliberately keeps the last result while disabled.
      state_q   <= IDLE;
      cnt_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      valid_q   <= 1'b0;
      slip_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      valid_q <= result;
      slip_q  <= slip_hit;
      if (result) begin
        error_q <= err_d;
        if (in_window) begin
          if (in_cnt_q != IN_FULL) in_cnt_q <= in_cnt_q + IN_W'(1);
          out_cnt_q <= '0;
        end else begin
          if (out_cnt_q != OUT_FULL) out_cnt_q <= out_cnt_q + OUT_W'(1);
          in_cnt_q <= '0;
        end
      end
      if (in_cnt_q == IN_FULL)        locked_q <= 1'b1;
      else if (out_cnt_q == OUT_FULL) locked_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (ref_e_q && !gen_e_q) begin
            cnt_q   <= '0;
            state_q <= WAIT_GEN;
          end else if (gen_e_q && !ref_e_q) begin
            cnt_q   <= '0;
            state_q <= WAIT_REF;
          end
        end
        WAIT_GEN, WAIT_REF: begin
          // A same-type edge always opens a fresh wait, with or without partner.
          if (same_e) begin
            cnt_q <= '0;
          end else if (partner_e || expired) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.error_o       = error_q;
  assign bus_if.error_valid_o = valid_q;
  assign bus_if.slip_o        = slip_q;
  assign bus_if.locked_o      = locked_q;
endmodule

// File: tb/tb_phase_detector_lock.sv
// Directed bench: a default instance and an ERR_W=4 instance share stimulus;
// expected errors, latencies and lock transitions are hand-computed.
module tb_phase_detector_lock;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en_r  = 1'b1;
  logic ref_r = 1'b0;
  logic gen_r = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  phase_detector_lock_if #(.ERR_W(8)) if8 ();
  phase_detector_lock_if #(.ERR_W(4)) if4 ();

  assign if8.enable_i  = en_r;
  assign if8.ref_clk_i = ref_r;
  assign if8.gen_clk_i = gen_r;
  assign if4.enable_i  = en_r;
  assign if4.ref_clk_i = ref_r;
  assign if4.gen_clk_i = gen_r;

  phase_detector_lock u_dut8 (
    .fpga_clk_i (clk),
    .reset_ni   (rst_n),
    .bus_if     (if8.slave)
  );

  phase_detector_lock #(.ERR_W(4)) u_dut4 (
    .fpga_clk_i (clk),
    .reset_ni   (rst_n),
    .bus_if     (if4.slave)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    ref_r = 1'b0;
    gen_r = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int bound, output bit ok, output int n,
                            output int e8, output int e4, output bit sl);
    ok = 1'b0; n = 0; e8 = 0; e4 = 0; sl = 1'b0;
    while (!ok && n < bound) begin
      @(negedge clk);
      n++;
      if (if8.error_valid_o) begin
        ok = 1'b1;
        e8 = int'(if8.error_o);
        e4 = int'(if4.error_o);
        sl = if8.slip_o;
      end
    end
  endtask

  // k > 0: gen lags ref by k cycles; k < 0: gen leads by -k; k == 0: same cycle.
  task automatic run(input string tag, input int k, input int exp8, input int exp4);
    bit ok, sl;
    int n, e8, e4;
    int a;
    a = (k < 0) ? -k : k;
    if (k >= 0) ref_r = 1'b1;
    if (k <= 0) gen_r = 1'b1;
    repeat (a) @(negedge clk);
    if (k > 0) gen_r = 1'b1;
    if (k < 0) ref_r = 1'b1;
    wait_valid(40, ok, n, e8, e4, sl);
    check({tag, ".found"}, int'(ok), 1);
    check({tag, ".err8"}, e8, exp8);
    check({tag, ".err4"}, e4, exp4);
    check({tag, ".slip"}, int'(sl), 0);
  endtask

  // n in-window results; locked_o must rise only the cycle after the 16th.
  task automatic lock_seq(input string tag, input int n);
    int win [16] = '{0, 1, -1, 2, -2, 0, 1, -1, 2, -2, 0, 1, -1, 2, -2, 1};
    for (int i = 0; i < n; i++) begin
      run($sformatf("%s[%0d]", tag, i), win[i], win[i], win[i]);
      @(negedge clk);
      check($sformatf("%s[%0d].locked", tag, i), int'(if8.locked_o), (i == 15) ? 1 : 0);
      idle(3);
    end
  endtask

  initial begin
    bit ok, sl;
    int n, e8, e4;

    // Reset state while reset_ni is low.
    #1;
    check("rst.err8", int'(if8.error_o), 0);
    check("rst.valid", int'(if8.error_valid_o), 0);
    check("rst.slip", int'(if8.slip_o), 0);
    check("rst.locked", int'(if8.locked_o), 0);
    check("rst.err4", int'(if4.error_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Case 1: gen lags ref by 5, single-cycle valid pulse.
    run("c1", 5, 5, 5);
    @(negedge clk);
    check("c1.pulse_end", int'(if8.error_valid_o), 0);
    idle(3);

    // Case 2: gen leads by 3; then same-cycle edges with latency check.
    run("c2.lead", -3, -3, -3);
    idle(4);
    ref_r = 1'b1;
    gen_r = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    check("c2.early", int'(if8.error_valid_o), 0);
    @(negedge clk);
    check("c2.valid", int'(if8.error_valid_o), 1);
    check("c2.err8", int'(if8.error_o), 0);
    check("c2.slip", int'(if8.slip_o), 0);
    idle(4);

    // Case 3a: timeout with gen held low.
    ref_r = 1'b1;
    wait_valid(400, ok, n, e8, e4, sl);
    check("c3.to.found", int'(ok), 1);
    check("c3.to.cycles", n, TIMEOUT + SYNC_STAGES + 2);
    check("c3.to.err8", e8, 127);
    check("c3.to.err4", e4, 7);
    check("c3.to.slip", int'(sl), 1);
    idle(4);
    run("c3.after_to", 5, 5, 5);
    idle(4);

    // Case 3b: two ref edges 40 cycles apart -> slip, then timing restarts.
    ref_r = 1'b1;
    repeat (10) @(negedge clk);
    ref_r = 1'b0;
    repeat (30) @(negedge clk);
    ref_r = 1'b1;
    wait_valid(40, ok, n, e8, e4, sl);
    check("c3.slip.found", int'(ok), 1);
    check("c3.slip.cycles", n, SYNC_STAGES + 2);
    check("c3.slip.err8", e8, 127);
    check("c3.slip.err4", e4, 7);
    check("c3.slip.slip", int'(sl), 1);
    repeat (3) @(negedge clk);
    gen_r = 1'b1;
    wait_valid(40, ok, n, e8, e4, sl);
    check("c3.restart.found", int'(ok), 1);
    check("c3.restart.err8", e8, 7);
    check("c3.restart.slip", int'(sl), 0);
    idle(4);

    // Case 5: saturation at ERR_W=4 is symmetric.
    run("c5.lag20", 20, 20, 7);
    idle(4);
    run("c5.lead20", -20, -20, -7);
    idle(4);

    // Case 4: one out-of-window result inside a run resets the in-window count.
    lock_seq("c4.pre", 10);
    run("c4.break", 10, 10, 7);
    idle(4);
    lock_seq("c4.lock", 16);
    for (int j = 0; j < 4; j++) begin
      run($sformatf("c4.out[%0d]", j), 10, 10, 7);
      @(negedge clk);
      check($sformatf("c4.out[%0d].locked", j), int'(if8.locked_o), (j < 3) ? 1 : 0);
      idle(3);
    end

    // Case 6a: enable dropped while locked.
    lock_seq("c6.relock", 16);
    en_r = 1'b0;
    @(negedge clk);
    check("c6.en.locked", int'(if8.locked_o), 0);
    check("c6.en.err8", int'(if8.error_o), 1);
    check("c6.en.valid", int'(if8.error_valid_o), 0);
    @(negedge clk);
    en_r = 1'b1;
    idle(2);
    lock_seq("c6.after_en", 16);

    // Case 6b: asynchronous reset in the middle of WAIT_GEN.
    ref_r = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("c6.rst.err8", int'(if8.error_o), 0);
    check("c6.rst.locked", int'(if8.locked_o), 0);
    check("c6.rst.valid", int'(if8.error_valid_o), 0);
    check("c6.rst.slip", int'(if8.slip_o), 0);
    ref_r = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    run("c6.post_rst", 5, 5, 5);
    idle(4);
    run("c6.post_rst_lead", -2, -2, -2);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
